// File: rtl/sp_sram_hold_pkg.sv
// Shared definitions for the behavioural SRAM: op encoding, decode helper and
// default geometry.
package sram_pkg;

  localparam int SRAM_ADDR_W = 6;
  localparam int SRAM_DATA_W = 28;

  typedef logic [1:0] op_t;

  localparam op_t OP_IDLE  = 2'd0;
  localparam op_t OP_READ  = 2'd1;
  localparam op_t OP_WRITE = 2'd2;

  // web_all_set is the AND-reduction of the per-bit write enables.
  function automatic op_t op_decode(input logic csb, input logic web_all_set);
    if (csb)              return OP_IDLE;
    else if (web_all_set) return OP_READ;
    else                  return OP_WRITE;
  endfunction

endpackage

// File: rtl/sp_sram_hold_if.sv
// Single-port SRAM access bus: the requester drives master, the memory is slave.
interface sp_sram_hold_if
  import sram_pkg::*;
#(
  parameter int ADDR_W = SRAM_ADDR_W,
  parameter int DATA_W = SRAM_DATA_W
);
  logic              csb;
  logic [DATA_W-1:0] web;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  logic              rd_valid;

  modport master (output csb, web, addr, din, input dout, rd_valid);
  modport slave  (input csb, web, addr, din, output dout, rd_valid);
endinterface

// File: rtl/sp_sram_hold_delay_pipe.sv
// Generic shift-register delay: NUM_STAGES synchronously reset registers in
// series; zero stages degenerates to a wire.
module delay_pipe #(
  parameter int NUM_STAGES = 1,
  parameter int DATA_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  if (NUM_STAGES == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
    assign dout = din;
  end else begin : g_regs
    logic [DATA_WIDTH-1:0] stage_q [NUM_STAGES];

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int i = 0; i < NUM_STAGES; i++) stage_q[i] <= '0;
      end else begin
        stage_q[0] <= din;
        for (int i = 1; i < NUM_STAGES; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign dout = stage_q[NUM_STAGES-1];
  end

endmodule

// File: rtl/sp_sram_hold.sv
// Behavioural single-port SRAM with bit-write mask, read latency pipe and
// read-data hold.
module sp_sram_hold
  import sram_pkg::*;
#(
  parameter int    ADDR_W    = SRAM_ADDR_W,
  parameter int    DEPTH     = 64,
  parameter int    DATA_W    = SRAM_DATA_W,
  parameter int    RD_LAT    = 1,
  parameter string INIT_FILE = ""
) (
  input logic           clk,
  input logic           rst_n,
  sp_sram_hold_if.slave bus
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam string unused_init_file = INIT_FILE;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_vld_q;
  logic [DATA_W-1:0] pipe_data;
  logic              pipe_valid;
  logic [DATA_W-1:0] hold_q;
  logic              in_range;
  op_t               op;

  assign op       = op_decode(bus.csb, &bus.web);
  assign in_range = ({1'b0, bus.addr} < DEPTH_L);

  // NOTE: the array has no reset branch so it maps onto plain storage; only
  // the read pipeline and hold register are cleared by rst_n.
  always_ff @(posedge clk) begin
    if (rst_n && op == OP_WRITE && in_range)
      mem[bus.addr] <= (mem[bus.addr] & bus.web) | (bus.din & ~bus.web);
  end

  // Array output register; an out-of-range read still completes, with zeros.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_vld_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      rd_vld_q <= (op == OP_READ);
      if (op == OP_READ) rd_data_q <= in_range ? mem[bus.addr] : '0;
    end
  end

  delay_pipe #(.NUM_STAGES(RD_LAT-1), .DATA_WIDTH(DATA_W)) u_data_pipe (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (rd_data_q),
    .dout (pipe_data)
  );

  delay_pipe #(.NUM_STAGES(RD_LAT-1), .DATA_WIDTH(1)) u_valid_pipe (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (rd_vld_q),
    .dout (pipe_valid)
  );

  always_ff @(posedge clk) begin
    if (!rst_n)          hold_q <= '0;
    else if (pipe_valid) hold_q <= pipe_data;
  end

  // Bypass the hold register on the completion cycle so new data is not delayed.
  assign bus.dout     = pipe_valid ? pipe_data : hold_q;
  assign bus.rd_valid = pipe_valid;

endmodule

// File: tb/tb_sp_sram_hold.sv
// Directed bench: one stimulus stream drives a RD_LAT=1/DEPTH=50 instance and a
// RD_LAT=3/DEPTH=64 instance, each checked against hand-computed values.
module tb_sp_sram_hold;

  localparam logic [27:0] ALL1 = 28'hFFFFFFF;

  logic        clk;
  logic        rst_n;
  logic        csb;
  logic [27:0] web;
  logic [5:0]  addr;
  logic [27:0] din;

  int errors = 0;
  int checks = 0;

  sp_sram_hold_if #(.ADDR_W(6), .DATA_W(28)) bus1 ();
  sp_sram_hold_if #(.ADDR_W(6), .DATA_W(28)) bus3 ();

  assign bus1.csb  = csb;
  assign bus1.web  = web;
  assign bus1.addr = addr;
  assign bus1.din  = din;
  assign bus3.csb  = csb;
  assign bus3.web  = web;
  assign bus3.addr = addr;
  assign bus3.din  = din;

  sp_sram_hold #(.ADDR_W(6), .DEPTH(50), .DATA_W(28), .RD_LAT(1)) u_lat1 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus1.slave)
  );

  sp_sram_hold #(.ADDR_W(6), .DEPTH(64), .DATA_W(28), .RD_LAT(3)) u_lat3 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus3.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Present one op, clock it in, and return 1ns after the edge for sampling.
  task automatic cyc(input logic c, input logic [27:0] w, input logic [5:0] a,
                     input logic [27:0] d);
    csb  = c;
    web  = w;
    addr = a;
    din  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b1, ALL1, 6'd0, 28'd0);
  endtask

  initial begin
    // Reset held two cycles with a read presented
    rst_n = 1'b0;
    cyc(1'b0, ALL1, 6'd5, 28'd0);
    cyc(1'b0, ALL1, 6'd5, 28'd0);
    check("rst_dout1", 32'(bus1.dout), 32'd0);
    check("rst_vld1",  32'(bus1.rd_valid), 32'd0);
    check("rst_dout3", 32'(bus3.dout), 32'd0);
    check("rst_vld3",  32'(bus3.rd_valid), 32'd0);
    rst_n = 1'b1;
    idle();
    check("post_rst_vld3", 32'(bus3.rd_valid), 32'd0);

    // Write then read addr 5
    cyc(1'b0, 28'd0, 6'd5, 28'hABCDEF1);
    check("wr_no_vld1",  32'(bus1.rd_valid), 32'd0);
    check("wr_no_dout1", 32'(bus1.dout), 32'd0);
    cyc(1'b0, ALL1, 6'd5, 28'd0);
    check("rd5_dout1", 32'(bus1.dout), 32'hABCDEF1);
    check("rd5_vld1",  32'(bus1.rd_valid), 32'd1);
    check("rd5_vld3_early", 32'(bus3.rd_valid), 32'd0);
    for (int i = 0; i < 10; i++) begin
      idle();
      check("hold_dout1", 32'(bus1.dout), 32'hABCDEF1);
      check("hold_vld1",  32'(bus1.rd_valid), 32'd0);
      check("lat3_vld",   32'(bus3.rd_valid), (i == 1) ? 32'd1 : 32'd0);
      if (i >= 1) check("lat3_dout", 32'(bus3.dout), 32'hABCDEF1);
    end

    // Bit-masked write: only the low byte is enabled
    cyc(1'b0, 28'd0, 6'd3, 28'd0);
    cyc(1'b0, 28'hFFFFF00, 6'd3, 28'hFFFFFFF);
    cyc(1'b0, ALL1, 6'd3, 28'd0);
    check("mask_dout1", 32'(bus1.dout), 32'h00000FF);
    check("mask_vld1",  32'(bus1.rd_valid), 32'd1);
    idle();
    idle();
    check("mask_dout3", 32'(bus3.dout), 32'h00000FF);
    check("mask_vld3",  32'(bus3.rd_valid), 32'd1);

    // Back-to-back reads of 0..3 holding 10..13
    for (int j = 0; j < 4; j++) cyc(1'b0, 28'd0, 6'(j), 28'(10 + j));
    for (int j = 0; j < 4; j++) begin
      cyc(1'b0, ALL1, 6'(j), 28'd0);
      check("b2b_dout1", 32'(bus1.dout), 32'(10 + j));
      check("b2b_vld1",  32'(bus1.rd_valid), 32'd1);
      check("b2b_vld3",  32'(bus3.rd_valid), (j >= 2) ? 32'd1 : 32'd0);
      if (j >= 2) check("b2b_dout3", 32'(bus3.dout), 32'(10 + j - 2));
    end
    for (int m = 0; m < 2; m++) begin
      idle();
      check("b2b_tail_dout3", 32'(bus3.dout), 32'(12 + m));
      check("b2b_tail_vld3",  32'(bus3.rd_valid), 32'd1);
    end
    idle();
    check("b2b_end_vld3",  32'(bus3.rd_valid), 32'd0);
    check("b2b_end_dout3", 32'(bus3.dout), 32'd13);

    // Address 60: beyond DEPTH=50 on lat1, in range on lat3
    cyc(1'b0, 28'd0, 6'd60, 28'h1234567);
    cyc(1'b0, ALL1, 6'd60, 28'd0);
    check("oor_dout1", 32'(bus1.dout), 32'd0);
    check("oor_vld1",  32'(bus1.rd_valid), 32'd1);
    idle();
    idle();
    check("a60_dout3", 32'(bus3.dout), 32'h1234567);

    // Read followed by write to the same address returns the old word
    cyc(1'b0, ALL1, 6'd5, 28'd0);
    check("rbw_dout1", 32'(bus1.dout), 32'hABCDEF1);
    cyc(1'b0, 28'd0, 6'd5, 28'h7654321);
    check("rbw_hold1", 32'(bus1.dout), 32'hABCDEF1);
    check("rbw_vld1",  32'(bus1.rd_valid), 32'd0);
    idle();
    check("rbw_dout3", 32'(bus3.dout), 32'hABCDEF1);
    idle();
    cyc(1'b0, ALL1, 6'd5, 28'd0);
    check("new5_dout1", 32'(bus1.dout), 32'h7654321);
    idle();
    idle();

    // Reset one cycle after a read cancels it
    cyc(1'b0, ALL1, 6'd2, 28'd0);
    check("pre_rst_dout1", 32'(bus1.dout), 32'd12);
    rst_n = 1'b0;
    cyc(1'b0, ALL1, 6'd1, 28'd0);
    check("mid_rst_dout1", 32'(bus1.dout), 32'd0);
    check("mid_rst_vld1",  32'(bus1.rd_valid), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idle();
      check("cancel_vld3",  32'(bus3.rd_valid), 32'd0);
      check("cancel_dout3", 32'(bus3.dout), 32'd0);
      check("cancel_vld1",  32'(bus1.rd_valid), 32'd0);
    end
    cyc(1'b0, ALL1, 6'd2, 28'd0);
    check("reread_dout1", 32'(bus1.dout), 32'd12);
    idle();
    idle();
    check("reread_dout3", 32'(bus3.dout), 32'd12);
    check("reread_vld3",  32'(bus3.rd_valid), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
